// File: rtl/l2_write_buffer_if.sv
// rtl/l2_write_buffer_if.sv - L2 memory port and cacheline-adaptor port bundle
interface l2_write_buffer_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata256, pmem_rdata, pmem_resp,
    output mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata256, pmem_rdata, pmem_resp,
    input  mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - posted write-back buffer between L2 and the cacheline adaptor
module l2_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  l2_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RESP, MISS, DRAIN} state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0] valid_q;
  logic [26:0]      tag_q  [DEPTH];
  logic [255:0]     data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic         mem_resp_q, mem_resp_d;
  logic [255:0] mem_rdata_q, mem_rdata_d;
  logic         pmem_read_q, pmem_read_d;
  logic         pmem_write_q, pmem_write_d;
  logic [31:0]  pmem_addr_q, pmem_addr_d;
  logic [255:0] pmem_wdata_q, pmem_wdata_d;

  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             pop;
  logic             go_drain;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.mem_address[4:0];

  // Tags are unique among valid entries, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == bus.mem_address[31:5])) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    mem_resp_d   = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    pmem_addr_d  = pmem_addr_q;
    pmem_wdata_d = pmem_wdata_q;
    wr_en        = 1'b0;
    wr_idx       = tail_q;
    pop          = 1'b0;
    go_drain     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_read) begin
          if (hit) begin
            mem_rdata_d = data_q[hit_idx];
            mem_resp_d  = 1'b1;
            state_d     = RESP;
          end else begin
            pmem_read_d = 1'b1;
            pmem_addr_d = {bus.mem_address[31:5], 5'b0};
            state_d     = MISS;
          end
        end else if (bus.mem_write) begin
          if (hit) begin
            wr_en      = 1'b1;
            wr_idx     = hit_idx;
            mem_resp_d = 1'b1;
            state_d    = RESP;
          end else if (count_q < CNT_W'(DEPTH)) begin
            wr_en      = 1'b1;
            tail_d     = tail_q + PTR_W'(1);
            count_d    = count_q + CNT_W'(1);
            mem_resp_d = 1'b1;
            state_d    = RESP;
          end else begin
            go_drain = 1'b1;
          end
        end else if (count_q != '0) begin
          go_drain = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      MISS: begin
        if (bus.pmem_resp) begin
          pmem_read_d = 1'b0;
          mem_rdata_d = bus.pmem_rdata;
          mem_resp_d  = 1'b1;
          state_d     = RESP;
        end
      end
      DRAIN: begin
        // Head stays valid (and hit-visible) until the adaptor acknowledges it.
        if (bus.pmem_resp) begin
          pmem_write_d = 1'b0;
          pop          = 1'b1;
          head_d       = head_q + PTR_W'(1);
          count_d      = count_q - CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_drain) begin
      pmem_write_d = 1'b1;
      pmem_addr_d  = {tag_q[head_q], 5'b0};
      pmem_wdata_d = data_q[head_q];
      state_d      = DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mem_resp_q   <= 1'b0;
      mem_rdata_q  <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mem_resp_q   <= mem_resp_d;
      mem_rdata_q  <= mem_rdata_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= bus.mem_address[31:5];
        data_q[wr_idx]  <= bus.mem_wdata256;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
    end
  end

  assign bus.mem_resp     = mem_resp_q;
  assign bus.mem_rdata256 = mem_rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_addr_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
endmodule

// File: doc/l2_write_buffer.md
# l2_write_buffer

Posted write-back buffer between the L2 cache's memory port and the cacheline adaptor. Dirty-line evictions from L2 are accepted into a small FIFO and acknowledged immediately, then drained to memory in idle time. L2 read misses are checked against buffered lines: hits are forwarded from the buffer, misses bypass pending drains. This removes eviction latency from the L2 miss path while keeping memory coherent for all reads.

## Interface
- DEPTH, 4, number of 256-bit line entries; power of two, ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_address  in  32  L2-side line address; bits [4:0] ignored.
- mem_read  in  1  L2 line read request, held until mem_resp.
- mem_write  in  1  L2 line write (eviction) request, held until mem_resp.
- mem_wdata256  in  256  L2 write line.
- mem_rdata256  out  256  line returned to L2; valid when mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse to L2.
- pmem_address  out  32  adaptor-side address, always {line[31:5],5'b0}.
- pmem_read  out  1  line read to adaptor, held until pmem_resp.
- pmem_write  out  1  line write to adaptor, held until pmem_resp.
- pmem_wdata  out  256  line written to adaptor; stable while pmem_write=1.
- pmem_rdata  in  256  line from adaptor; valid when pmem_resp=1.
- pmem_resp  in  1  adaptor completion pulse.

## Operation
- Storage: DEPTH entries {valid, tag[31:5], data[255:0]}, circular FIFO with head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
- Hit = any valid entry whose tag equals mem_address[31:5]; tags are unique across valid entries (coalescing guarantees it).
- FSM states: IDLE, RESP, MISS, DRAIN. Priority in IDLE: mem_read, then mem_write, then drain.
- IDLE, mem_read & hit: latch matching entry data into mem_rdata256 → RESP.
- IDLE, mem_read & miss: → MISS.
- IDLE, mem_write & hit on non-head-in-drain entry: overwrite that entry's data in place (coalesce), count unchanged → RESP.
- IDLE, mem_write & no hit & count<DEPTH: write tail entry, tail++, count++ → RESP.
- IDLE, mem_write & no hit & count==DEPTH: → DRAIN (write stalls, retried in IDLE afterwards).
- IDLE, no request & count>0: → DRAIN.
- MISS: pmem_read=1, pmem_address={mem_address[31:5],5'b0}; on pmem_resp latch pmem_rdata into mem_rdata256 → RESP.
- DRAIN: pmem_write=1, address/data from head entry; on pmem_resp clear head valid, head++, count-- → IDLE. A drain is never aborted.
- RESP: mem_resp=1 for exactly one cycle → IDLE.
- Head entry remains valid and hit-visible until its pmem_resp, so reads to a draining line are forwarded correctly.
- mem_read and mem_write both high is illegal; read wins.

## Timing
- Reset values: mem_resp=0, mem_rdata256=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0; count=0, head=tail=0, all valid=0; state IDLE.
- All outputs registered.
- Write accept latency: request seen in IDLE at cycle N → mem_resp at N+1.
- Read hit latency: mem_resp at N+1 with buffered data.
- Read miss latency: pmem_read asserted at N+1; mem_resp one cycle after pmem_resp. If a DRAIN is in flight, the read waits for its pmem_resp and then one IDLE cycle.
- Full buffer write: mem_resp no earlier than 2 cycles after the drain's pmem_resp.
- pmem_read and pmem_write never high together; pmem_address/pmem_wdata stable for the full handshake.
- Reset mid-drain or mid-miss: outputs drop immediately (asynchronous); buffered data is discarded.

## Test plan
- Write A=0x00001000 data D0 with empty buffer → mem_resp at +1, count=1; idle → pmem_write to 0x00001000 with D0, after pmem_resp count=0.
- Four writes to distinct lines 0x100,0x200,0x300,0x400 back-to-back with L2 read stalled and adaptor resp delayed 10 cycles → fifth write 0x500 stalls until first drain resp, drain order 0x100..0x400 FIFO.
- Write 0x2000 D1 then write 0x2000 D2 before drain → count=1, single pmem_write carrying D2.
- Write 0x3000 D3, then read 0x3000 → mem_resp at +1 with D3, no pmem_read.
- Read miss 0x4000 while drain of 0x5000 in flight → pmem_read only after drain pmem_resp, mem_rdata256=pmem_rdata, mem_resp one cycle after pmem_resp.
- Assert rst during DRAIN → pmem_write=0 immediately, count=0, no further pmem activity.
